// File: rtl/lsu.sv
// Load/store unit: takes one execute-stage result at a time, runs a single
// data-bus transaction for memory ops and returns the writeback result.
module lsu #(
    parameter int TIMEOUT       = 16,
    parameter bit BYPASS_NONMEM = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    output logic        req_ready_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_waddr;
    logic        r_we;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_waddr;
    logic [31:0] r_wb_wdata;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_is_mem;
    logic        w_aligned;
    logic        w_in_req;

    function automatic logic f_is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] f_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_HALF: return lsb[0] == 1'b0;
            SZ_WORD: return lsb == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 4'b0001 << lsb;
            SZ_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Stores replicate the payload so every lane the slave might pick holds it.
    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [3:0] op, input logic [1:0] lsb,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lsb[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LBU:  return {24'd0, b};
            OP_LHU:  return {16'd0, h};
            OP_LW:   return d;
            default: return 32'd0;
        endcase
    endfunction

    assign w_is_mem  = f_is_mem(mem_op_i);
    assign w_aligned = f_aligned(f_size(mem_op_i), addr_i[1:0]);
    assign w_in_req  = (r_state == S_REQ);

    // Bus outputs are decoded from the state register so reset drops them at once.
    assign dbus_req_o   = w_in_req;
    assign dbus_we_o    = w_in_req && f_is_store(r_op);
    assign dbus_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dbus_be_o    = w_in_req ? f_be(f_size(r_op), r_addr[1:0]) : 4'd0;
    assign dbus_wdata_o = w_in_req ? f_wdata(f_size(r_op), r_wdata) : 32'd0;

    assign req_ready_o  = (r_state == S_IDLE);
    assign stall_o      = (r_state == S_REQ) || (r_state == S_WAIT);
    assign wb_valid_o   = r_wb_valid;
    assign wb_we_o      = r_wb_we;
    assign wb_waddr_o   = r_wb_waddr;
    assign wb_wdata_o   = r_wb_wdata;
    assign misalign_o   = r_misalign;
    assign bus_err_o    = r_bus_err;

    // Request payload is only consumed while a transaction is in flight.
    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && req_valid_i && w_is_mem && w_aligned) begin
            r_op    <= mem_op_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_waddr <= reg_waddr_i;
            r_we    <= reg_we_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= 5'd0;
            r_wb_wdata <= 32'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (w_is_mem) begin
                            if (w_aligned) begin
                                r_state <= S_REQ;
                            end else begin
                                r_misalign <= 1'b1;
                            end
                        end else if (BYPASS_NONMEM) begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= reg_we_i && (reg_waddr_i != 5'd0);
                            r_wb_waddr <= reg_waddr_i;
                            r_wb_wdata <= addr_i;
                        end
                    end
                end
                S_REQ: begin
                    if (dbus_gnt_i) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A response on the last counted cycle beats the timeout.
                    if (dbus_rvalid_i) begin
                        r_state    <= S_RESP;
                        r_cnt      <= 8'd0;
                        r_wb_valid <= 1'b1;
                        r_wb_waddr <= r_waddr;
                        r_wb_we    <= !f_is_store(r_op) && r_we && (r_waddr != 5'd0);
                        r_wb_wdata <= f_is_store(r_op) ? 32'd0
                                                       : f_load(r_op, r_addr[1:0], dbus_rdata_i);
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 8'd0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed bus transactions, bypass, timeout and
// reset-abort cases plus a short randomized load/store loop.
`timescale 1ns/1ps
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic        req_ready_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    always #5 clk_i = ~clk_i;

    lsu #(.TIMEOUT(16), .BYPASS_NONMEM(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .reg_we_i     (reg_we_i),
        .reg_waddr_i  (reg_waddr_i),
        .req_ready_o  (req_ready_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_gnt_i   (dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i (dbus_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        chk_data;
    } wb_t;

    wb_t sb[$];
    int  n_chk   = 0;
    int  n_pass  = 0;
    int  n_wb    = 0;
    int  n_extra = 0;
    int  n_mis   = 0;
    int  n_berr  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] be_model(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 4'b0001 << a[1:0];
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wd_model(input logic [3:0] op, input logic [31:0] w);
        if (op == 4'd6) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (op == 4'd7) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] ld_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] s;
        s = d >> (8 * a[1:0]);
        case (op)
            4'd1:    return {{24{s[7]}}, s[7:0]};
            4'd2:    return {{16{s[15]}}, s[15:0]};
            4'd4:    return {24'd0, s[7:0]};
            4'd5:    return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (misalign_o) n_mis++;
            if (bus_err_o) n_berr++;
            if (wb_valid_o) begin
                n_wb++;
                if (sb.size() == 0) begin
                    n_extra++;
                end else begin
                    wb_t e;
                    e = sb.pop_front();
                    check("wb_we", 32'(wb_we_o), 32'(e.we));
                    check("wb_waddr", 32'(wb_waddr_o), 32'(e.waddr));
                    if (e.chk_data) check("wb_wdata", wb_wdata_o, e.data);
                end
            end
        end
    end

    task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rd, input logic we);
        req_valid_i = 1'b1;
        mem_op_i    = op;
        addr_i      = a;
        wdata_i     = wd;
        reg_waddr_i = rd;
        reg_we_i    = we;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        mem_op_i    = 4'd0;
        addr_i      = 32'hDEAD_BEEF;
        wdata_i     = 32'hFFFF_FFFF;
        reg_waddr_i = 5'd0;
        reg_we_i    = 1'b0;
    endtask

    task automatic mem_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] rd, input logic we, input int gd, input int rv,
                           input logic [31:0] rdata, input logic [3:0] ebe,
                           input logic [31:0] ebaddr, input logic [31:0] ebwd, input wb_t ewb);
        int wb0;
        wb0 = n_wb;
        check("ready_idle", 32'(req_ready_o), 32'd1);
        drive_req(op, a, wd, rd, we);
        tick();
        idle_inputs();
        check("stall_req", 32'(stall_o), 32'd1);
        check("ready_req", 32'(req_ready_o), 32'd0);
        repeat (gd) tick();
        check("dbus_req", 32'(dbus_req_o), 32'd1);
        check("dbus_we", 32'(dbus_we_o), 32'(op >= 4'd6));
        check("dbus_addr", dbus_addr_o, ebaddr);
        check("dbus_be", 32'(dbus_be_o), 32'(ebe));
        if (op >= 4'd6) check("dbus_wdata", dbus_wdata_o, ebwd);
        dbus_gnt_i = 1'b1;
        tick();
        dbus_gnt_i = 1'b0;
        check("dbus_req_drop", 32'(dbus_req_o), 32'd0);
        check("stall_wait", 32'(stall_o), 32'd1);
        repeat (rv) tick();
        sb.push_back(ewb);
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rdata;
        tick();
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        check("stall_resp", 32'(stall_o), 32'd0);
        check("no_bus_err", 32'(bus_err_o), 32'd0);
        tick();
        check("wb_single", 32'(wb_valid_o), 32'd0);
        check("wb_pulses", 32'(n_wb - wb0), 32'd1);
        check("ready_back", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wb_t e;
        rst_i         = 1'b1;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_dbus_req", 32'(dbus_req_o), 32'd0);
        check("rst_be", 32'(dbus_be_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_exc", 32'({misalign_o, bus_err_o}), 32'd0);
        rst_i = 1'b0;
        tick();

        // LB sign-extended from lane 3
        mem_txn(4'd1, 32'h103, 32'h0, 5'd1, 1'b1, 2, 1, 32'h80FF_FFFF, 4'b1000,
                32'h100, 32'h0, '{1'b1, 5'd1, 32'hFFFF_FF80, 1'b1});
        // LHU from upper half
        mem_txn(4'd5, 32'h102, 32'h0, 5'd2, 1'b1, 0, 0, 32'h8001_1234, 4'b1100,
                32'h100, 32'h0, '{1'b1, 5'd2, 32'h0000_8001, 1'b1});
        // SH replicated, no register write
        mem_txn(4'd7, 32'h206, 32'h0000_ABCD, 5'd4, 1'b1, 1, 0, 32'h0, 4'b1100,
                32'h204, 32'hABCD_ABCD, '{1'b0, 5'd4, 32'h0, 1'b0});
        // LW to x0 never writes
        mem_txn(4'd3, 32'h208, 32'h0, 5'd0, 1'b1, 0, 0, 32'h1234_5678, 4'b1111,
                32'h208, 32'h0, '{1'b0, 5'd0, 32'h1234_5678, 1'b1});

        // Misaligned word and halfword
        drive_req(4'd3, 32'h101, 32'h0, 5'd3, 1'b1);
        tick();
        idle_inputs();
        check("mis_pulse", 32'(misalign_o), 32'd1);
        check("mis_no_req", 32'(dbus_req_o), 32'd0);
        check("mis_idle", 32'(req_ready_o), 32'd1);
        tick();
        check("mis_one_cycle", 32'(misalign_o), 32'd0);
        drive_req(4'd2, 32'h103, 32'h0, 5'd3, 1'b1);
        tick();
        idle_inputs();
        check("mis_half", 32'(misalign_o), 32'd1);
        tick();

        // Stray bus handshakes while idle are ignored
        dbus_gnt_i    = 1'b1;
        dbus_rvalid_i = 1'b1;
        tick();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        check("stray_idle", 32'(req_ready_o), 32'd1);
        check("stray_stall", 32'(stall_o), 32'd0);

        // Timeout with no response
        drive_req(4'd3, 32'h300, 32'h0, 5'd7, 1'b1);
        tick();
        idle_inputs();
        dbus_gnt_i = 1'b1;
        tick();
        dbus_gnt_i = 1'b0;
        repeat (15) tick();
        check("berr_early", 32'(bus_err_o), 32'd0);
        check("stall_w16", 32'(stall_o), 32'd1);
        tick();
        check("bus_err", 32'(bus_err_o), 32'd1);
        check("stall_after_err", 32'(stall_o), 32'd0);
        check("ready_after_err", 32'(req_ready_o), 32'd1);
        tick();
        check("bus_err_pulse", 32'(bus_err_o), 32'd0);

        // Response on the 16th WAIT cycle still wins
        mem_txn(4'd3, 32'h304, 32'h0, 5'd8, 1'b1, 0, 15, 32'hCAFE_F00D, 4'b1111,
                32'h304, 32'h0, '{1'b1, 5'd8, 32'hCAFE_F00D, 1'b1});

        // Non-memory bypass, including an out-of-range op code and x0
        e = '{1'b1, 5'd3, 32'h77, 1'b1};
        sb.push_back(e);
        drive_req(4'd12, 32'h77, 32'h0, 5'd3, 1'b1);
        tick();
        e = '{1'b0, 5'd0, 32'h1234, 1'b1};
        sb.push_back(e);
        drive_req(4'd0, 32'h1234, 32'h0, 5'd0, 1'b1);
        tick();
        idle_inputs();
        check("bypass_idle", 32'(req_ready_o), 32'd1);
        tick();

        // Reset in REQ drops the bus request without waiting for a clock
        drive_req(4'd3, 32'h400, 32'h0, 5'd9, 1'b1);
        tick();
        idle_inputs();
        check("req_before_rst", 32'(dbus_req_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_req", 32'(dbus_req_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Reset in WAIT, stale response afterwards, then bypass
        drive_req(4'd3, 32'h404, 32'h0, 5'd9, 1'b1);
        tick();
        idle_inputs();
        dbus_gnt_i = 1'b1;
        tick();
        dbus_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_async_stall", 32'(stall_o), 32'd0);
        check("rst_async_ready", 32'(req_ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'hBAD0_BAD0;
        tick();
        dbus_rvalid_i = 1'b0;
        check("no_stale_wb", 32'(wb_valid_o), 32'd0);
        e = '{1'b1, 5'd5, 32'h55, 1'b1};
        sb.push_back(e);
        drive_req(4'd0, 32'h55, 32'h0, 5'd5, 1'b1);
        tick();
        idle_inputs();
        check("post_rst_wb_valid", 32'(wb_valid_o), 32'd1);
        check("post_rst_waddr", 32'(wb_waddr_o), 32'd5);
        check("post_rst_wdata", wb_wdata_o, 32'h55);
        tick();

        // Randomized loads and stores against the reference model
        for (int k = 0; k < 10; k++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rdat;
            logic [4:0]  rd;
            wb_t         ex;
            op   = 4'($urandom_range(1, 8));
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            rd   = 5'($urandom);
            if (op == 4'd2 || op == 4'd5 || op == 4'd7) a[0] = 1'b0;
            if (op == 4'd3 || op == 4'd8) a[1:0] = 2'b00;
            if (op >= 4'd6) ex = '{1'b0, rd, 32'h0, 1'b0};
            else            ex = '{(rd != 5'd0), rd, ld_model(op, a, rdat), 1'b1};
            mem_txn(op, a, wd, rd, 1'b1, $urandom_range(0, 2), $urandom_range(0, 3), rdat,
                    be_model(op, a), {a[31:2], 2'b00}, wd_model(op, wd), ex);
        end

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("wb_extra", 32'(n_extra), 32'd0);
        check("misalign_count", 32'(n_mis), 32'd2);
        check("bus_err_count", 32'(n_berr), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum cycles spent in WAIT before a bus error; legal range 2..255.
REQ-002 Parameter BYPASS_NONMEM, default 1, when 1 passes non-memory results through with 1-cycle latency; when 0, non-memory requests are dropped.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high (`RstEnable = 1'b1).
REQ-005 req_valid_i  in  1  execute-stage result valid this cycle.
REQ-006 mem_op_i  in  4  memory operation: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE.
REQ-007 addr_i  in  32  ALU result: the effective address, or the writeback data for NONE.
REQ-008 wdata_i  in  32  store data (rs2).
REQ-009 reg_we_i  in  1  and reg_waddr_i  in  5  destination register from execute.
REQ-010 req_ready_o  out  1  block can accept a request this cycle.
REQ-011 dbus_req_o  out  1, dbus_we_o  out  1, dbus_addr_o  out  32 (bits [1:0]=0), dbus_wdata_o  out  32, dbus_be_o  out  4  data-bus request.
REQ-012 dbus_gnt_i  in  1  request accepted; dbus_rvalid_i  in  1  response valid; dbus_rdata_i  in  32  read data.
REQ-013 wb_valid_o  out  1, wb_we_o  out  1, wb_waddr_o  out  5, wb_wdata_o  out  32  writeback to the register file.
REQ-014 stall_o  out  1  freezes the upstream pipeline.
REQ-015 misalign_o  out  1  and bus_err_o  out  1  are one-cycle exception pulses.

Function
REQ-016 FSM states are IDLE, REQ, WAIT and RESP; the reset state is IDLE.
REQ-017 req_ready_o SHALL be 1 only in IDLE.
REQ-018 In IDLE with req_valid_i=1 and a memory op, the block SHALL check alignment: a halfword requires addr[0]=0 and a word requires addr[1:0]=0.
REQ-019 On a misaligned request, the block SHALL pulse misalign_o the next cycle, issue no bus request and no writeback, and stay in IDLE.
REQ-020 On an aligned request, the block SHALL latch op, addr, wdata, reg_waddr and reg_we, and move to REQ.
REQ-021 In REQ, dbus_req_o SHALL be 1 with all bus outputs stable until dbus_gnt_i=1; the transition is to WAIT on the same edge.
REQ-022 Byte enables: a byte access SHALL drive be = 1<<addr[1:0]; a halfword SHALL drive 4'b0011 or 4'b1100 per addr[1]; a word SHALL drive 4'b1111.
REQ-023 Store data SHALL be replicated across lanes: SB {4{b}}, SH {2{h}}, SW unchanged.
REQ-024 In WAIT, the block SHALL count cycles; dbus_rvalid_i=1 moves to RESP with rdata captured.
REQ-025 If the WAIT count reaches TIMEOUT, the block SHALL pulse bus_err_o, perform no writeback, and return to IDLE.
REQ-026 In RESP, the block SHALL drive wb_valid_o=1 for exactly one cycle and then return to IDLE.
REQ-027 Loads in RESP: wb_we_o SHALL equal the latched reg_we; data SHALL be the lane selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU/LW.
REQ-028 Stores in RESP: wb_we_o SHALL be 0.
REQ-029 Writes to x0: wb_we_o SHALL be 0 whenever wb_waddr_o=0.
REQ-030 NONE op with BYPASS_NONMEM=1: the next cycle SHALL show wb_valid_o=1, wb_wdata_o=addr_i, wb_waddr_o/wb_we_o from the inputs, and the FSM stays IDLE.
REQ-031 stall_o SHALL be 1 in REQ and WAIT, and 0 in IDLE and RESP.
REQ-032 dbus_rvalid_i outside WAIT and dbus_gnt_i outside REQ SHALL be ignored.
REQ-033 req_valid_i SHALL be ignored in REQ, WAIT and RESP; upstream holds its request because stall_o or req_ready_o is low.
REQ-034 rdata arriving in the same cycle as the final timeout count SHALL be accepted, so the response wins over the timeout.

Reset
REQ-035 While rst_i=1, the block SHALL be in IDLE with all outputs 0 except req_ready_o=1, and the WAIT counter cleared.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately: dbus_req_o drops asynchronously and no writeback or exception pulse follows.

Verification
REQ-037 LB at addr 0x103, rdata 0x80FFFFFF, gnt after 2 cycles, rvalid after 1 -> be=4'b1000, wb_wdata_o=0xFFFFFF80, a single wb_valid_o pulse.
REQ-038 LHU at addr 0x102, rdata 0x8001_1234 -> be=4'b1100, wb_wdata_o=0x00008001.
REQ-039 SH at addr 0x206, wdata 0x0000ABCD -> dbus_wdata_o=0xABCDABCD, be=4'b1100, dbus_addr_o=0x204, wb_we_o=0.
REQ-040 LW at addr 0x101 -> misalign_o pulses once, dbus_req_o stays 0, wb_valid_o stays 0.
REQ-041 LW granted, with no rvalid for 16 cycles -> bus_err_o pulses, FSM returns to IDLE, stall_o drops; a second case with rvalid on the 16th cycle -> normal writeback and no bus_err_o.
REQ-042 rst_i pulsed while in WAIT; then NONE op with addr 0x55 to x5 -> no stale writeback, and the next cycle shows wb_valid_o=1, wb_waddr_o=5, wb_wdata_o=0x55.
